// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;

    localparam int NREQ_DEFAULT = 2;
    localparam int W_DEFAULT    = 32;

    // Widest operand the all-ones constant covers; the top slices it down to W.
    localparam int W_MAX = 64;
    localparam logic [W_MAX-1:0] Q_ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from ptr with wrap and returns a one-hot
// grant plus the binary index of the winner.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    logic          found;
    logic [PW-1:0] cand;

    // First requester at or above ptr (modulo NREQ) wins.
    always_comb begin
        // NOTE: every variable gets a default before the search loop so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((32'(ptr) + 32'(i)) % 32'(NREQ));
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between NREQ requesters.
// IDLE grants round-robin, START pulses the divider, WAIT watches div_busy
// rise then fall, RESP holds the result until the owner accepts it.
// Optional build macro DIV_ZERO_BYPASS_EN: a zero divisor skips the divider
// and answers directly with all-ones quotient, remainder = dividend, dbz = 1.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    input  logic [NREQ-1:0]   req_signed,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_q,
    output logic [W-1:0]      rsp_r,
    output logic              rsp_dbz,
    output logic              div_start,
    output logic              div_reset,
    output logic              div_signed,
    output logic [W-1:0]      div_dividend,
    output logic [W-1:0]      div_divisor,
    input  logic              div_busy,
    input  logic [W-1:0]      div_q,
    input  logic [W-1:0]      div_r
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, owner, grant_idx, ptr_after;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    op_a, op_b, sel_a, sel_b;
    logic            op_s, sel_s;
    logic            busy_seen;
    logic            accept, complete, zero_bypass, owner_ready, abort;
    logic [W-1:0]    q_reg, r_reg;
    logic            dbz_reg;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Operand mux for the requester the arbiter picked this cycle.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_dividend[i*W +: W];
                sel_b = req_divisor[i*W +: W];
                sel_s = req_signed[i];
            end
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (sel_b == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    assign accept      = (state == ST_IDLE) && (|req_valid);
    assign complete    = busy_seen && !div_busy;
    assign owner_ready = rsp_ready[owner];
    assign abort       = flush && ((state == ST_START) || (state == ST_WAIT));
    assign ptr_after   = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // Next state and the handshake/control outputs.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        // Divider is held in reset for the whole of reset_n low, clock or not.
        div_reset = !reset_n || abort;
        case (state)
            ST_IDLE: begin
                if (reset_n) begin
                    req_ready = grant;
                end
                if (accept) begin
                    state_nxt = zero_bypass ? ST_RESP : ST_START;
                end
            end
            ST_START: begin
                div_start = !flush;
                state_nxt = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // Flush wins over a completion landing in the same cycle.
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (complete) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                for (int i = 0; i < NREQ; i++) begin
                    rsp_valid[i] = (owner == PW'(i));
                end
                if (owner_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, round-robin pointer, latched transaction and response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_s      <= 1'b0;
            busy_seen <= 1'b0;
            q_reg     <= '0;
            r_reg     <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner     <= grant_idx;
                        op_a      <= sel_a;
                        op_b      <= sel_b;
                        op_s      <= sel_s;
                        busy_seen <= 1'b0;
                        if (zero_bypass) begin
                            q_reg   <= Q_ALL_ONES[W-1:0];
                            r_reg   <= sel_a;
                            dbz_reg <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!flush) begin
                        if (div_busy) begin
                            busy_seen <= 1'b1;
                        end
                        if (complete) begin
                            q_reg   <= div_q;
                            r_reg   <= div_r;
                            dbz_reg <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    if (owner_ready) begin
                        ptr <= ptr_after;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_q        = q_reg;
    assign rsp_r        = r_reg;
    assign rsp_dbz      = dbz_reg;
    assign div_dividend = op_a;
    assign div_divisor  = op_b;
    assign div_signed   = op_s;

endmodule
